// File: rtl/mcif_arb_ctrl5.sv
// Sequencing controller for a 5-client round-robin memory-interface arbiter.
// Registers the winner returned by the external picker, issues one command per grant and tracks burst beats.
module mcif_arb_ctrl5 #(
  parameter int         LEN_W     = 8,
  parameter logic [2:0] PRIO_INIT = 3'd4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [4:0]         cli_req,
  input  logic [5*LEN_W-1:0] cli_len,
  input  logic [2:0]         nxt_arb_id,
  output logic [4:0]         arb_req,
  output logic               arb_en,
  output logic [2:0]         cur_arb_id,
  output logic [4:0]         cli_gnt,
  output logic [4:0]         cli_done,
  output logic               mem_cmd_valid,
  input  logic               mem_cmd_ready,
  output logic [2:0]         mem_cmd_id,
  output logic [LEN_W-1:0]   mem_cmd_len,
  input  logic               mem_beat,
  output logic               busy,
  output logic               err_beat
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ARB  = 2'd1;
  localparam logic [1:0] CMD  = 2'd2;
  localparam logic [1:0] XFER = 2'd3;

  logic [1:0]       state_reg, state_next;
  logic [2:0]       cur_id_reg, cur_id_next;
  logic [LEN_W-1:0] len_reg, len_next;
  logic [LEN_W-1:0] cnt_reg, cnt_next;
  logic             err_reg;

  logic [LEN_W-1:0] len_arr [5];
  logic [4:0]       cur_onehot;
  logic [LEN_W-1:0] nxt_len;
  logic             req_any;
  logic             nxt_ok;
  logic             cmd_acc;
  logic             last_beat;

  generate
    for (genvar gi = 0; gi < 5; gi++) begin : g_cli
      assign len_arr[gi]    = cli_len[gi*LEN_W +: LEN_W];
      assign cur_onehot[gi] = (cur_id_reg == 3'(gi));
    end
  endgenerate

  always_comb begin
    nxt_len = '0;
    for (int i = 0; i < 5; i++) begin
      if (nxt_arb_id == 3'(i)) nxt_len = len_arr[i];
    end
  end

  assign req_any   = |cli_req;
  assign nxt_ok    = (nxt_arb_id <= 3'd4);
  assign cmd_acc   = (state_reg == CMD) && mem_cmd_ready;
  assign last_beat = (state_reg == XFER) && mem_beat && (cnt_reg == len_reg);

  always_comb begin
    state_next  = state_reg;
    cur_id_next = cur_id_reg;
    len_next    = len_reg;
    cnt_next    = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (req_any) state_next = ARB;
      end
      ARB: begin
        // An out-of-range picker result is treated like an empty request vector.
        if (req_any && nxt_ok) begin
          cur_id_next = nxt_arb_id;
          len_next    = nxt_len;
          state_next  = CMD;
        end else begin
          state_next = IDLE;
        end
      end
      CMD: begin
        if (mem_cmd_ready) begin
          cnt_next   = '0;
          state_next = XFER;
        end
      end
      XFER: begin
        if (mem_beat) begin
          if (cnt_reg == len_reg) begin
            state_next = req_any ? ARB : IDLE;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      cur_id_reg <= PRIO_INIT;
      len_reg    <= '0;
      cnt_reg    <= '0;
      err_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cur_id_reg <= cur_id_next;
      len_reg    <= len_next;
      cnt_reg    <= cnt_next;
      // Beats arriving without an accepted command are flagged, never counted.
      if (mem_beat && (state_reg != XFER)) err_reg <= 1'b1;
    end
  end

  assign arb_req       = cli_req;
  assign arb_en        = (state_reg == ARB);
  assign busy          = (state_reg != IDLE);
  assign mem_cmd_valid = (state_reg == CMD);
  assign mem_cmd_id    = cur_id_reg;
  assign mem_cmd_len   = len_reg;
  assign cur_arb_id    = cur_id_reg;
  assign cli_gnt       = cmd_acc ? cur_onehot : 5'b0;
  assign cli_done      = last_beat ? cur_onehot : 5'b0;
  assign err_beat      = err_reg;

endmodule

// File: tb/tb_mcif_arb_ctrl5.sv
// Scoreboard bench for mcif_arb_ctrl5: a round-robin model predicts grant order and burst lengths,
// a negedge monitor checks commands, grants, done pulses and the done-to-command gap.
module tb_mcif_arb_ctrl5;
  localparam int LEN_W = 8;

  typedef struct {
    logic [2:0]       id;
    logic [LEN_W-1:0] len;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [4:0]         cli_req = '0;
  logic [5*LEN_W-1:0] cli_len = '0;
  logic [2:0]         nxt_arb_id;
  logic [4:0]         arb_req;
  logic               arb_en;
  logic [2:0]         cur_arb_id;
  logic [4:0]         cli_gnt;
  logic [4:0]         cli_done;
  logic               mem_cmd_valid;
  logic               mem_cmd_ready = 1'b0;
  logic [2:0]         mem_cmd_id;
  logic [LEN_W-1:0]   mem_cmd_len;
  logic               mem_beat = 1'b0;
  logic               busy;
  logic               err_beat;

  int n_chk = 0;
  int n_fail = 0;

  exp_t exp_q[$];
  logic [2:0] model_last = 3'd4;

  // environment knobs
  logic       ovr_en = 1'b0;
  logic [2:0] ovr_val = 3'd7;
  logic       mem_en = 1'b0;
  int         ready_pct = 100;
  int         beat_pct = 100;
  int         stall_cnt = 0;
  int         beats_left = 0;
  logic       pend_accept = 1'b0;
  logic [2:0] pend_id = '0;

  // monitor state
  logic mon_in_xfer = 1'b0;
  int   mon_id = 0;
  int   mon_beats = 0;
  int   mon_seen = 0;
  int   mon_cyc = 0;
  int   done_cyc = 0;
  logic done_pend = 1'b0;
  logic prev_valid = 1'b0;

  always #5 clk = ~clk;

  function automatic logic [2:0] rr_pick(input logic [2:0] last, input logic [4:0] m);
    for (int k = 1; k <= 5; k++) begin
      int c;
      c = (int'(last) + k) % 5;
      if (m[c]) return 3'(c);
    end
    return 3'd7;
  endfunction

  // The picker is part of the environment, fed from the DUT's own feedback outputs.
  assign nxt_arb_id = ovr_en ? ovr_val : rr_pick(cur_arb_id, arb_req);

  mcif_arb_ctrl5 #(.LEN_W(LEN_W), .PRIO_INIT(3'd4)) dut (
    .clk(clk), .rst_n(rst_n), .cli_req(cli_req), .cli_len(cli_len),
    .nxt_arb_id(nxt_arb_id), .arb_req(arb_req), .arb_en(arb_en),
    .cur_arb_id(cur_arb_id), .cli_gnt(cli_gnt), .cli_done(cli_done),
    .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready),
    .mem_cmd_id(mem_cmd_id), .mem_cmd_len(mem_cmd_len), .mem_beat(mem_beat),
    .busy(busy), .err_beat(err_beat)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: event not seen as required (t=%0t)", name, $time);
  endtask

  task automatic set_len(input int i, input logic [LEN_W-1:0] v);
    cli_len[i*LEN_W +: LEN_W] = v;
  endtask

  // One clock step; when enabled, also acts as memory side and drops granted requests.
  task automatic cycle();
    @(posedge clk);
    #1;
    if (mem_en) begin
      if (pend_accept) begin
        beats_left  = int'(mem_cmd_len) + 1;
        cli_req[pend_id] = 1'b0;
        pend_accept = 1'b0;
      end
      mem_beat = 1'b0;
      if (beats_left > 0 && int'($urandom_range(99)) < beat_pct) begin
        mem_beat = 1'b1;
        beats_left--;
      end
      if (mem_cmd_valid) begin
        if (stall_cnt > 0) begin
          mem_cmd_ready = 1'b0;
          stall_cnt--;
        end else begin
          mem_cmd_ready = (int'($urandom_range(99)) < ready_pct);
        end
        if (mem_cmd_ready) begin
          pend_accept = 1'b1;
          pend_id     = mem_cmd_id;
        end
      end else begin
        mem_cmd_ready = 1'($urandom_range(1));
      end
    end
  endtask

  // Issue a request set from IDLE and predict every grant in round-robin order.
  task automatic run_set(input logic [4:0] mask, input int rp, input int bp);
    logic [4:0] m;
    logic [2:0] w;
    bit done;
    exp_t e;
    m = mask;
    while (m != 0) begin
      w = rr_pick(model_last, m);
      e.id  = w;
      e.len = cli_len[int'(w)*LEN_W +: LEN_W];
      exp_q.push_back(e);
      $display("push: mask=%b winner=%0d len=%0d", mask, w, e.len);
      model_last = w;
      m[w] = 1'b0;
    end
    ready_pct = rp;
    beat_pct  = bp;
    cli_req   = mask;
    cycle();
    chk("arb_en_latency", 32'(arb_en), 32'd1);
    chk("valid_not_early", 32'(mem_cmd_valid), 32'd0);
    cycle();
    chk("valid_latency", 32'(mem_cmd_valid), 32'd1);
    done = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      cycle();
      if (exp_q.size() == 0 && !busy && !mon_in_xfer) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      fail_now("set_timeout");
      exp_q.delete();
    end
    chk("cur_id_after_set", 32'(cur_arb_id), 32'(model_last));
  endtask

  // Monitor: compares DUT outputs against the scoreboard each cycle on the falling edge.
  initial begin
    exp_t e;
    logic acc;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mon_in_xfer = 1'b0;
        done_pend   = 1'b0;
        prev_valid  = 1'b0;
      end else begin
        mon_cyc++;
        chk("arb_req", 32'(arb_req), 32'(cli_req));
        acc = mem_cmd_valid && mem_cmd_ready;
        if (mon_in_xfer && mem_beat) begin
          mon_seen++;
          if (mon_seen == mon_beats) begin
            chk("done_pulse", 32'(cli_done), 32'(1) << mon_id);
            $display("done: client=%0d beats=%0d", mon_id, mon_seen);
            mon_in_xfer = 1'b0;
            done_pend   = (cli_req != 0);
            done_cyc    = mon_cyc;
          end else begin
            chk("done_early", 32'(cli_done), 32'd0);
          end
        end else begin
          chk("done_quiet", 32'(cli_done), 32'd0);
        end
        if (mem_cmd_valid && !prev_valid && done_pend) begin
          chk("done_to_valid_gap", 32'(mon_cyc - done_cyc), 32'd2);
          done_pend = 1'b0;
        end
        if (mem_cmd_valid) begin
          if (exp_q.size() == 0) begin
            fail_now("cmd_expected");
          end else begin
            e = exp_q[0];
            chk("cmd_id", 32'(mem_cmd_id), 32'(e.id));
            chk("cmd_len", 32'(mem_cmd_len), 32'(e.len));
            chk("gnt", 32'(cli_gnt), acc ? (32'(1) << e.id) : 32'd0);
            if (acc) begin
              chk("cur_id_at_grant", 32'(cur_arb_id), 32'(e.id));
              $display("grant: client=%0d len=%0d", e.id, e.len);
              void'(exp_q.pop_front());
              mon_in_xfer = 1'b1;
              mon_id      = int'(e.id);
              mon_beats   = int'(e.len) + 1;
              mon_seen    = 0;
            end
          end
        end else begin
          chk("gnt_quiet", 32'(cli_gnt), 32'd0);
        end
        prev_valid = mem_cmd_valid;
      end
    end
  end

  initial begin
    exp_t e;
    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cur_id", 32'(cur_arb_id), 32'd4);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(mem_cmd_valid), 32'd0);
    chk("rst_arb_en", 32'(arb_en), 32'd0);
    chk("rst_err", 32'(err_beat), 32'd0);
    chk("rst_pulses", 32'({cli_gnt, cli_done}), 32'd0);
    rst_n = 1'b1;
    mem_en = 1'b1;
    cycle();

    // single client, four beats
    set_len(0, 8'd3);
    run_set(5'b00001, 100, 100);

    // all clients, single-beat bursts, immediate ready
    for (int i = 0; i < 5; i++) set_len(i, 8'd0);
    run_set(5'b11111, 100, 100);

    // park on client 2, then 0 must precede 2; first command stalled five cycles
    set_len(2, 8'd2);
    run_set(5'b00100, 100, 100);
    set_len(0, 8'd5);
    stall_cnt = 5;
    run_set(5'b00101, 100, 100);
    chk("err_clean", 32'(err_beat), 32'd0);

    // request withdrawn during the arbitration cycle
    mem_en = 1'b0;
    mem_cmd_ready = 1'b0;
    mem_beat = 1'b0;
    cli_req = 5'b00010;
    cycle();
    chk("withdraw_arb", 32'(arb_en), 32'd1);
    cli_req = 5'b00000;
    cycle();
    chk("withdraw_idle", 32'(busy), 32'd0);
    repeat (3) begin
      cycle();
      chk("withdraw_no_valid", 32'(mem_cmd_valid), 32'd0);
    end
    chk("withdraw_cur_id", 32'(cur_arb_id), 32'(model_last));

    // out-of-range picker result falls back to IDLE
    ovr_en = 1'b1;
    ovr_val = 3'd7;
    cli_req = 5'b00001;
    cycle();
    chk("badid_arb", 32'(arb_en), 32'd1);
    cycle();
    chk("badid_idle", 32'(busy), 32'd0);
    cli_req = 5'b00000;
    ovr_en = 1'b0;
    cycle();
    chk("badid_cur_id", 32'(cur_arb_id), 32'(model_last));

    // stray beat in IDLE sets the sticky error
    mem_beat = 1'b1;
    cycle();
    mem_beat = 1'b0;
    cycle();
    chk("err_set", 32'(err_beat), 32'd1);
    repeat (3) cycle();
    chk("err_sticky", 32'(err_beat), 32'd1);

    // async reset two beats into an eight-beat burst
    set_len(0, 8'd7);
    e.id = 3'd0;
    e.len = 8'd7;
    exp_q.push_back(e);
    model_last = 3'd0;
    cli_req = 5'b00001;
    cycle();
    cycle();
    chk("rstx_valid", 32'(mem_cmd_valid), 32'd1);
    mem_cmd_ready = 1'b1;
    cycle();
    mem_cmd_ready = 1'b0;
    mem_beat = 1'b1;
    cycle();
    cycle();
    mem_beat = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    chk("rstx_busy", 32'(busy), 32'd0);
    chk("rstx_done", 32'(cli_done), 32'd0);
    chk("rstx_cur_id", 32'(cur_arb_id), 32'd4);
    chk("rstx_err", 32'(err_beat), 32'd0);
    cli_req = 5'b00000;
    model_last = 3'd4;
    exp_q.delete();
    cycle();
    cycle();
    beats_left = 0;
    pend_accept = 1'b0;
    rst_n = 1'b1;
    mem_en = 1'b1;
    set_len(0, 8'd1);
    set_len(4, 8'd2);
    run_set(5'b10001, 100, 100);

    // randomized request sets with stalls and gapped beats
    for (int t = 0; t < 30; t++) begin
      for (int i = 0; i < 5; i++) set_len(i, 8'($urandom_range(6)));
      run_set(5'($urandom_range(31, 1)), 50, 60);
    end
    chk("final_err", 32'(err_beat), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
